// File: rtl/seq_mag_compare_ctrl.sv
// Drives one shared external 2-bit magnitude comparator to compare WIDTH-bit operands, MSB slice
// first. Optional two's-complement mode is enabled by defining COMPARE_SIGNED_EN.
module seq_mag_compare_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             a_eq_b,
  output logic             cmp_a1,
  output logic             cmp_a0,
  output logic             cmp_b1,
  output logic             cmp_b0,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             cmp_eq
);

  localparam int unsigned NS = WIDTH / 2;
  localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] IdxTop = IW'(NS - 1);

  typedef enum logic [1:0] {StIdle, StCmp, StDone} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [WIDTH-1:0] a_shift, b_shift;
  logic [2:0]       cmp_res;
  logic             cmp_onehot;

  // Current slice sits in the low two bits after shifting by 2*idx.
  assign a_shift = a_q >> {idx_q, 1'b0};
  assign b_shift = b_q >> {idx_q, 1'b0};

  always_comb begin
    cmp_a1 = a_shift[1];
    cmp_a0 = a_shift[0];
    cmp_b1 = b_shift[1];
    cmp_b0 = b_shift[0];
`ifdef COMPARE_SIGNED_EN
    // Flipping the sign bits maps two's complement onto unsigned ordering.
    if (state_q == StCmp && idx_q == IdxTop) begin
      cmp_a1 = ~a_q[WIDTH-1];
      cmp_b1 = ~b_q[WIDTH-1];
    end
`endif
  end

  assign cmp_res    = {cmp_gt, cmp_lt, cmp_eq};
  assign cmp_onehot = (cmp_res == 3'b100) || (cmp_res == 3'b010) || (cmp_res == 3'b001);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = IdxTop;
          state_d = StCmp;
        end
      end
      StCmp: begin
        if (cmp_eq && idx_q != '0) begin
          idx_d = idx_q - 1'b1;
        end else begin
          state_d = StDone;
          if (cmp_onehot) begin
            {gt_d, lt_d, eq_d} = cmp_res;
          end else begin
            {gt_d, lt_d, eq_d} = 3'b001;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign ready  = (state_q == StIdle);
  assign busy   = ~ready;
  assign done   = (state_q == StDone);
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;
  assign a_eq_b = eq_q;

endmodule
